// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_BITS = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_nibble.sv
// Purely combinational 4-bit ripple-carry slice; c3 is the carry into the top bit,
// needed by the sequencer to form signed overflow on the last nibble.
module rca_nibble
  import rca_seq_pkg::*;
(
  input  logic [NIB_BITS-1:0] a,
  input  logic [NIB_BITS-1:0] b,
  input  logic                cin,
  output logic [NIB_BITS-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIB_BITS:0] c_s;

  // Bit-by-bit ripple through the slice
  always_comb begin
    s      = '0;
    c_s    = '0;
    c_s[0] = cin;
    for (int i = 0; i < NIB_BITS; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[NIB_BITS];
  assign c3   = c_s[NIB_BITS-1];

endmodule

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit ripple slice, LSB nibble first,
// with valid/ready handshakes on both sides.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (((WIDTH % NIB_BITS) != 0) || (WIDTH < NIB_BITS)) begin : g_width_chk
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  accept_s;
  logic                  last_s;
  logic [IDX_W-1:0]      idx_r;
  logic                  carry_r;
  logic [WIDTH-1:0]      opa_r;
  logic [WIDTH-1:0]      opb_r;
  logic [WIDTH-1:0]      sum_r;
  logic                  cout_r;
  logic                  ovf_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic [NIB_BITS-1:0]   nib_a_s;
  logic [NIB_BITS-1:0]   nib_b_s;
  logic [NIB_BITS-1:0]   slice_sum_s;
  logic                  slice_cout_s;
  logic                  slice_c3_s;

  // Next-state decode and accept strobe
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Current nibble of each latched operand
  always_comb begin
    nib_a_s = opa_r[idx_r*NIB_BITS +: NIB_BITS];
    nib_b_s = opb_r[idx_r*NIB_BITS +: NIB_BITS];
  end

  rca_nibble u_slice (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s),
    .c3   (slice_c3_s)
  );

  // State register; handshake flags are registered from the next state so they
  // line up with the state they describe and clear instantly on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Operand capture and one nibble of arithmetic per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      opa_r   <= '0;
      opb_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      opa_r   <= a;
      opb_r   <= (op_sub == OP_SUB) ? ~b : b;
      carry_r <= op_sub;
      idx_r   <= '0;
      sum_r   <= '0;
    end else if (state_r == RUN) begin
      sum_r[idx_r*NIB_BITS +: NIB_BITS] <= slice_sum_s;
      carry_r <= slice_cout_s;
      if (last_s) begin
        cout_r <= slice_cout_s;
        ovf_r  <= slice_c3_s ^ slice_cout_s;
      end else begin
        idx_r  <= idx_r + 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and randomized bench for rca_seq_ctrl (WIDTH=16 and WIDTH=4 instances)
// against a plain-arithmetic reference model.
module tb_rca_seq_ctrl;

  logic        clk;
  logic        rst;

  logic        in_valid16, in_ready16, op_sub16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cout16, ovf16, busy16;

  logic        in_valid4, in_ready4, op_sub4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cout4, ovf4, busy4;

  int n_cmp;
  int n_fail;

  rca_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid16), .in_ready (in_ready16), .op_sub (op_sub16),
    .a (a16), .b (b16),
    .out_valid (out_valid16), .out_ready (out_ready16),
    .sum (sum16), .cout (cout16), .ovf (ovf16), .busy (busy16)
  );

  rca_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid4), .in_ready (in_ready4), .op_sub (op_sub4),
    .a (a4), .b (b4),
    .out_valid (out_valid4), .out_ready (out_ready4),
    .sum (sum4), .cout (cout4), .ovf (ovf4), .busy (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 16-bit operation; hold = cycles out_ready stays low once in DONE,
  // during which a competing request is presented on the input side.
  task automatic op16(input logic sub, input logic [15:0] ta, input logic [15:0] tb_, input int hold);
    logic [15:0] bb;
    logic [16:0] full;
    logic        eovf;
    int          w, lat, low;
    bb   = sub ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + {16'd0, sub};
    eovf = (ta[15] == bb[15]) && (full[15] != ta[15]);
    w = 0;
    while (!in_ready16 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait16", 32'(w < 50), 32'd1);
    out_ready16 = (hold == 0);
    op_sub16 = sub; a16 = ta; b16 = tb_; in_valid16 = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) begin
      in_valid16 = 1'b0;
    end else begin
      a16 = 16'($urandom); b16 = 16'($urandom); op_sub16 = ~sub;
    end
    lat = 0; low = 0;
    while (!out_valid16 && lat < 20) begin
      if (!in_ready16) low++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency16", 32'(lat), 32'd4);
    chk("sum16", 32'(sum16), 32'(full[15:0]));
    chk("cout16", 32'(cout16), 32'(full[16]));
    chk("ovf16", 32'(ovf16), 32'(eovf));
    chk("busy16_done", 32'(busy16), 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (!in_ready16) low++;
      @(posedge clk); #1;
      chk("hold_valid16", 32'(out_valid16), 32'd1);
      chk("hold_sum16", 32'({ovf16, cout16, sum16}), 32'({eovf, full[16], full[15:0]}));
    end
    out_ready16 = 1'b1;
    if (!in_ready16) low++;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("valid_drop16", 32'(out_valid16), 32'd0);
    chk("idle_ready16", 32'({busy16, in_ready16}), 32'b01);
    chk("ready_low_cycles16", 32'(low), 32'(5 + hold));
  endtask

  // One 4-bit operation with the consumer always ready.
  task automatic op4(input logic sub, input logic [3:0] ta, input logic [3:0] tb_);
    logic [3:0] bb;
    logic [4:0] full;
    logic       eovf;
    int         w, lat;
    bb   = sub ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + {4'd0, sub};
    eovf = (ta[3] == bb[3]) && (full[3] != ta[3]);
    w = 0;
    while (!in_ready4 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait4", 32'(w < 50), 32'd1);
    out_ready4 = 1'b1;
    op_sub4 = sub; a4 = ta; b4 = tb_; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency4", 32'(lat), 32'd1);
    chk("sum4", 32'({ovf4, cout4, sum4}), 32'({eovf, full[4], full[3:0]}));
    @(posedge clk); #1;
    chk("valid_drop4", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    logic saw;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    in_valid16 = 1'b0; op_sub16 = 1'b0; a16 = 16'd0; b16 = 16'd0; out_ready16 = 1'b0;
    in_valid4 = 1'b0; op_sub4 = 1'b0; a4 = 4'd0; b4 = 4'd0; out_ready4 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs16", 32'({in_ready16, out_valid16, busy16, cout16, ovf16, sum16}), 32'd0);
    chk("rst_outs4", 32'({in_ready4, out_valid4, busy4, cout4, ovf4, sum4}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst16", 32'(in_ready16), 32'd1);
    chk("ready_after_rst4", 32'(in_ready4), 32'd1);

    op16(1'b0, 16'h1234, 16'h4321, 0);
    op16(1'b0, 16'hFFFF, 16'h0001, 0);
    op16(1'b0, 16'h7FFF, 16'h0001, 0);
    op16(1'b1, 16'h0005, 16'h0007, 0);
    op16(1'b1, 16'h8000, 16'h0001, 0);
    op16(1'b1, 16'h1234, 16'h1234, 0);
    op16(1'b0, 16'hABCD, 16'h1111, 6);

    // Abort mid-RUN with an asynchronous reset
    out_ready16 = 1'b1;
    op_sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("partial_sum16", 32'(sum16), 32'h0055);
    #2 rst = 1'b1;
    #1;
    chk("async_rst16", 32'({in_ready16, out_valid16, busy16, cout16, ovf16, sum16}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid16) saw = 1'b1;
    end
    chk("no_result_after_abort", 32'(saw), 32'd0);
    op16(1'b0, 16'h0F0F, 16'h00F1, 0);

    for (int k = 0; k < 24; k++) begin
      op16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    op4(1'b0, 4'h9, 4'h8);
    op4(1'b1, 4'h3, 4'h5);
    for (int k = 0; k < 8; k++) begin
      op4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
- Holds the inter-nibble carry in a register.
- Wraps the arithmetic in valid/ready handshakes on input and output.
- Sits between an operand source (register file or ALU front end) and a result consumer, trading latency for one 4-bit adder's area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration-time assertion).
- NIB, WIDTH/4, derived; number of nibble steps per operation (localparam, not overridable).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept an operation (high only in IDLE).
- op_sub  input  1  0 = A+B, 1 = A−B (two's complement); sampled with operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, registered.
- cout  output  1  unsigned carry-out; for subtract, 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset values: state = IDLE; sum, cout, ovf, out_valid, busy = 0; in_ready = 1 once reset is released; idx = 0; carry register = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a into opA and (op_sub ? ~b : b) into opB; carry <= op_sub; idx <= 0; clear sum; go to RUN.
- RUN:
  - Each cycle the slice adds opA[4*idx +: 4], opB[4*idx +: 4] and carry.
  - sum[4*idx +: 4] <= slice S; carry <= slice Cout; idx <= idx + 1.
  - When idx == NIB−1: cout <= slice Cout; ovf <= slice carry into bit 3 XOR slice Cout; go to DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable until the handshake.
  - On out_valid & out_ready, go to IDLE the next cycle (out_valid drops).
- Latency: out_valid rises NIB clock edges after the accepting edge. With out_ready held high, issue interval is NIB+2 cycles. No overlap of operations.
- Arithmetic: modulo 2^WIDTH.
  - sum, cout and ovf are bit-exact with a WIDTH-bit adder given Cin = op_sub and B' = op_sub ? ~b : b.
- idx is $clog2(NIB) bits wide (minimum 1) and never exceeds NIB−1.
- Boundary cases:
  - NIB = 1: RUN lasts exactly one cycle.
  - Full carry ripple across all nibbles must propagate through the carry register with no loss.
  - out_ready held high while entering DONE: out_valid is still high for at least one cycle.
  - out_ready may be asserted before out_valid; it has no effect outside DONE.
  - Reset asserted in RUN or DONE: immediate abort to IDLE, outputs to reset values, no result emitted.
  - After reset release, the first accept behaves normally.

Decomposition:
- Package rca_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - NIB_BITS = 4 constant.
  - OP_ADD / OP_SUB encodings.
- Sub-module rca_nibble: purely combinational 4-bit ripple-carry slice.
  - Ports: a[3:0], b[3:0], cin, s[3:0], cout, c3 (carry into bit 3).
  - Instantiated once.

Test Plan (WIDTH=16 unless stated):
- add 0x1234 + 0x4321, out_ready = 1 -> sum = 0x5555, cout = 0, ovf = 0; out_valid exactly 4 edges after accept; in_ready low for 5 cycles.
- add 0xFFFF + 0x0001 -> sum = 0x0000, cout = 1, ovf = 0 (carry ripples through all 4 nibble steps); add 0x7FFF + 0x0001 -> sum = 0x8000, cout = 0, ovf = 1.
- sub 0x0005 − 0x0007 -> sum = 0xFFFE, cout = 0; sub 0x8000 − 0x0001 -> sum = 0x7FFF, cout = 1, ovf = 1; sub 0x1234 − 0x1234 -> sum = 0x0000, cout = 1, ovf = 0.
- Backpressure: out_ready = 0 for 6 cycles in DONE, in_valid = 1 with new operands -> sum/cout/ovf stable, in_ready = 0, new request accepted only after the output handshake plus one IDLE cycle.
- Reset asserted asynchronously mid-RUN (idx = 2) -> all outputs 0 without waiting for a clock edge, no out_valid; after release, 0x0F0F + 0x00F1 -> 0x1000.
- WIDTH=4 instance: add 0x9 + 0x8 -> sum = 0x1, cout = 1, ovf = 1; out_valid 1 edge after accept.
